forward_unit: RTL
=================

FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, datapath width; REG_AW, default 5, register address width; NUM_SRC, default 2, EX source operands; HIST_DEPTH, default 2, retired-write bypass entries (1..4).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: stall_in  in  1  external pipeline freeze (cache miss).
REQ-005 SHALL have ports: id_rs_addr  in  NUM_SRC*REG_AW  ID-stage source addresses; ex_rs_addr  in  NUM_SRC*REG_AW  EX-stage source addresses; ex_rs_data  in  NUM_SRC*DATA_W  regfile read data.
REQ-006 SHALL have ports: ex_rd_addr  in  REG_AW; ex_mem_read  in  1  EX holds a load.
REQ-007 SHALL have ports: mem_rd_addr  in  REG_AW; mem_reg_write  in  1; mem_mem_read  in  1; mem_alu_out  in  DATA_W.
REQ-008 SHALL have ports: wb_rd_addr  in  REG_AW; wb_reg_write  in  1; wb_data  in  DATA_W.
REQ-009 SHALL have ports: fwd_sel  out  NUM_SRC*2  per-operand select; fwd_data  out  NUM_SRC*DATA_W  forwarded operands; hazard_stall  out  1  freeze IF/ID, bubble EX; fwd_err  out  1  sticky error; stall_cnt  out  32  stall cycle counter.

Function
REQ-010 SHALL compute each operand's fwd_sel/fwd_data combinationally in the same cycle (zero latency).
REQ-011 SHALL encode fwd_sel: 00 ex_rs_data, 01 wb_data, 10 mem_alu_out, 11 history buffer.
REQ-012 SHALL apply priority MEM > WB > history entry 0 (newest) > ... > entry HIST_DEPTH-1 > ex_rs_data.
REQ-013 SHALL never forward for source address 0; operand then passes ex_rs_data with sel 00.
REQ-014 SHALL qualify matches: MEM needs mem_reg_write=1, WB needs wb_reg_write=1, history needs entry valid bit.
REQ-015 SHALL hold a HIST_DEPTH-entry shift buffer of {valid, addr, data}; on each cycle with stall_in=0 and wb_reg_write=1 and wb_rd_addr!=0 push wb write into entry 0 and shift; with wb_reg_write=0 and stall_in=0 push an invalid entry.
REQ-016 SHALL freeze the history buffer while stall_in=1.
REQ-017 SHALL run FSM with states IDLE, BUBBLE, HOLD.
REQ-018 SHALL in IDLE with stall_in=0 assert hazard_stall combinationally when ex_mem_read=1, ex_rd_addr!=0 and any id_rs_addr equals ex_rd_addr, and transition to BUBBLE.
REQ-019 SHALL in BUBBLE deassert hazard_stall and return to IDLE next cycle (exactly one bubble per load).
REQ-020 SHALL in any state enter HOLD when stall_in=1, keep hazard_stall=0 (external freeze governs), and return to the state held at entry when stall_in drops.
REQ-021 SHALL, when stall_in and a load-use condition coincide in IDLE, take HOLD first and evaluate load-use after release.
REQ-022 SHALL set fwd_err and keep it until reset when an operand matches mem_rd_addr with mem_mem_read=1 and mem_reg_write=1 (load data unavailable); fwd_sel still reports 10.
REQ-023 SHALL increment stall_cnt on every cycle hazard_stall=1 or stall_in=1, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-024 SHALL on rst=0 at a clock edge: FSM to IDLE, all history valid bits to 0, fwd_err 0, stall_cnt 0; reset dominates stall_in.
REQ-025 SHALL drive hazard_stall 0 during reset; fwd_sel/fwd_data remain combinational from inputs and cleared history.

Structure
REQ-026 SHALL place fwd_sel encodings and FSM state constants in shared package cpu_pkg.
REQ-027 SHALL implement per-operand select logic as sub-module fwd_operand_sel, instantiated NUM_SRC times via generate.

Verification
REQ-028 SHALL cover: MEM and WB both write r5, ex_rs_addr0=5 -> fwd_sel0=10, fwd_data0=mem_alu_out.
REQ-029 SHALL cover: wb writes r7=0x1234, next cycle no writes, ex_rs_addr1=7, regfile returns 0 -> fwd_sel1=11, fwd_data1=0x1234.
REQ-030 SHALL cover: EX load to r3, id_rs_addr0=3 -> hazard_stall=1 one cycle only, stall_cnt=1, FSM IDLE after two cycles.
REQ-031 SHALL cover: stall_in held 4 cycles with pending load-use -> hazard_stall 0 during hold, 1 for one cycle after release, stall_cnt=5, history unchanged during hold.
REQ-032 SHALL cover: source address 0 with MEM writing r0 -> fwd_sel=00; MEM load r9 with ex_rs_addr0=9 -> fwd_err=1 sticky until rst=0.
REQ-033 SHALL cover: rst=0 mid-BUBBLE with valid history -> next cycle FSM IDLE, history hits absent (sel 00), stall_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared forwarding-select encodings and hazard FSM state constants.
package cpu_pkg;

    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_EX   = 2'b00;
    localparam fwd_sel_t FWD_WB   = 2'b01;
    localparam fwd_sel_t FWD_MEM  = 2'b10;
    localparam fwd_sel_t FWD_HIST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUBBLE = 2'b01,
        ST_HOLD   = 2'b10
    } fsm_state_t;

endpackage

// File: rtl/fwd_operand_sel.sv
// Bypass source selection for one EX operand: MEM > WB > history (newest first) > regfile.
module fwd_operand_sel
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic [REG_AW-1:0]            rs_addr,
    input  logic [DATA_W-1:0]            rs_data,
    input  logic [REG_AW-1:0]            mem_rd_addr,
    input  logic                         mem_reg_write,
    input  logic                         mem_mem_read,
    input  logic [DATA_W-1:0]            mem_alu_out,
    input  logic [REG_AW-1:0]            wb_rd_addr,
    input  logic                         wb_reg_write,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic [HIST_DEPTH-1:0]        hist_valid,
    input  logic [HIST_DEPTH*REG_AW-1:0] hist_addr,
    input  logic [HIST_DEPTH*DATA_W-1:0] hist_data,
    output fwd_sel_t                     sel_c,
    output logic [DATA_W-1:0]            data_c,
    output logic                         load_err_c
);

    // Lowest priority first so later matches overwrite earlier ones; r0 never forwards.
    always_comb begin
        sel_c      = FWD_EX;
        data_c     = rs_data;
        load_err_c = 1'b0;
        if (rs_addr != '0) begin
            for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
                if (hist_valid[i] && (hist_addr[i*REG_AW +: REG_AW] == rs_addr)) begin
                    sel_c  = FWD_HIST;
                    data_c = hist_data[i*DATA_W +: DATA_W];
                end
            end
            if (wb_reg_write && (wb_rd_addr == rs_addr)) begin
                sel_c  = FWD_WB;
                data_c = wb_data;
            end
            if (mem_reg_write && (mem_rd_addr == rs_addr)) begin
                sel_c      = FWD_MEM;
                data_c     = mem_alu_out;
                load_err_c = mem_mem_read;
            end
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding, retired-write history bypass and load-use hazard control.
module forward_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_in,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs_addr,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_rs_data,
    input  logic [REG_AW-1:0]           ex_rd_addr,
    input  logic                        ex_mem_read,
    input  logic [REG_AW-1:0]           mem_rd_addr,
    input  logic                        mem_reg_write,
    input  logic                        mem_mem_read,
    input  logic [DATA_W-1:0]           mem_alu_out,
    input  logic [REG_AW-1:0]           wb_rd_addr,
    input  logic                        wb_reg_write,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        hazard_stall,
    output logic                        fwd_err,
    output logic [31:0]                 stall_cnt
);

    logic [HIST_DEPTH-1:0]        hist_valid_q;
    logic [HIST_DEPTH*REG_AW-1:0] hist_addr_q;
    logic [HIST_DEPTH*DATA_W-1:0] hist_data_q;
    logic [NUM_SRC-1:0]           load_err_c;
    logic                         load_use_c;
    logic                         stall_c;
    fsm_state_t                   state_q, state_d;
    fsm_state_t                   held_q, held_d;
    fsm_state_t                   eff_state_c;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_operand_sel #(
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_sel (
            .rs_addr       (ex_rs_addr[g*REG_AW +: REG_AW]),
            .rs_data       (ex_rs_data[g*DATA_W +: DATA_W]),
            .mem_rd_addr   (mem_rd_addr),
            .mem_reg_write (mem_reg_write),
            .mem_mem_read  (mem_mem_read),
            .mem_alu_out   (mem_alu_out),
            .wb_rd_addr    (wb_rd_addr),
            .wb_reg_write  (wb_reg_write),
            .wb_data       (wb_data),
            .hist_valid    (hist_valid_q),
            .hist_addr     (hist_addr_q),
            .hist_data     (hist_data_q),
            .sel_c         (fwd_sel[g*SEL_W +: SEL_W]),
            .data_c        (fwd_data[g*DATA_W +: DATA_W]),
            .load_err_c    (load_err_c[g])
        );
    end

    // History valid bits: newest retired write enters at entry 0, frozen during external stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_valid_q <= '0;
        end else if (!stall_in) begin
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
                hist_valid_q[i] <= hist_valid_q[i-1];
            end
            hist_valid_q[0] <= wb_reg_write && (wb_rd_addr != '0);
        end
    end

    // History payload needs no reset; it is only consumed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!stall_in) begin
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
                hist_addr_q[i*REG_AW +: REG_AW] <= hist_addr_q[(i-1)*REG_AW +: REG_AW];
                hist_data_q[i*DATA_W +: DATA_W] <= hist_data_q[(i-1)*DATA_W +: DATA_W];
            end
            hist_addr_q[REG_AW-1:0] <= wb_rd_addr;
            hist_data_q[DATA_W-1:0] <= wb_data;
        end
    end

    always_comb begin
        load_use_c = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_rs_addr[i*REG_AW +: REG_AW] == ex_rd_addr) begin
                load_use_c = 1'b1;
            end
        end
        load_use_c = load_use_c && ex_mem_read && (ex_rd_addr != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            held_q  <= ST_IDLE;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Leaving HOLD behaves exactly like the state that was frozen, so a pending load-use stalls on release.
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        stall_c      = 1'b0;
        eff_state_c  = (state_q == ST_HOLD) ? held_q : state_q;
        if (stall_in) begin
            if (state_q != ST_HOLD) begin
                state_d = ST_HOLD;
                held_d  = state_q;
            end
        end else begin
            case (eff_state_c)
                ST_IDLE: begin
                    if (load_use_c) begin
                        stall_c = 1'b1;
                        state_d = ST_BUBBLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUBBLE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
        hazard_stall = stall_c && rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_err   <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            fwd_err <= fwd_err || (|load_err_c);
            if (hazard_stall || stall_in) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule
